// File: rtl/conv_tap_accumulator.sv
// Sums KLEN consecutive accepted products into one convolution sample and presents
// it on a valid/ready port with a wrapping sample index; flush aborts a partial window.
module conv_tap_accumulator #(
  parameter  int PW   = 8,
  parameter  int KLEN = 3,
  parameter  int AW   = 10,
  parameter  int IW   = 8,
  localparam int TW   = $clog2(KLEN + 1)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [PW-1:0] prod,
  input  logic          prod_valid,
  output logic          prod_ready,
  input  logic          flush,
  output logic [AW-1:0] acc_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [TW-1:0] tap_cnt,
  output logic          busy
);

  localparam logic [TW-1:0] LAST_TAP = TW'(KLEN - 1);

  logic [AW-1:0] acc_reg;
  logic [TW-1:0] tap_cnt_reg;
  logic [AW-1:0] acc_out_reg;
  logic          out_valid_reg;
  logic [IW-1:0] out_idx_reg;
  logic [IW-1:0] sample_cnt_reg;

  logic [AW-1:0] sum_next;
  logic          accept;
  logic          is_final;
  logic          transfer;

  // Upstream stalls only while a finished sample is waiting and not being taken.
  assign prod_ready = !(out_valid_reg && !out_ready);
  assign accept     = prod_valid && prod_ready && !flush;
  assign is_final   = (tap_cnt_reg == LAST_TAP);
  assign transfer   = out_valid_reg && out_ready;
  assign sum_next   = acc_reg + AW'(prod);

  // Window accumulator; acc_reg is zero at the start of every window.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      tap_cnt_reg <= '0;
    end else if (flush) begin
      acc_reg     <= '0;
      tap_cnt_reg <= '0;
    end else if (accept) begin
      if (is_final) begin
        acc_reg     <= '0;
        tap_cnt_reg <= '0;
      end else begin
        acc_reg     <= sum_next;
        tap_cnt_reg <= tap_cnt_reg + TW'(1);
      end
    end
  end

  // Output register; an emit on the same edge as a transfer keeps out_valid high.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      acc_out_reg    <= '0;
      out_valid_reg  <= 1'b0;
      out_idx_reg    <= '0;
      sample_cnt_reg <= '0;
    end else if (accept && is_final) begin
      acc_out_reg    <= sum_next;
      out_valid_reg  <= 1'b1;
      out_idx_reg    <= sample_cnt_reg;
      sample_cnt_reg <= sample_cnt_reg + IW'(1);
    end else if (transfer) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign acc_out   = acc_out_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign tap_cnt   = tap_cnt_reg;
  assign busy      = (tap_cnt_reg != '0) || out_valid_reg;

endmodule

// File: doc/conv_tap_accumulator.md
Name: conv_tap_accumulator

Overview:
- Sits directly downstream of the 4x4 unsigned product stage (product width 8) in the 1D convolution datapath.
- Sums KLEN consecutive accepted products into one convolution output sample.
- Presents the sum on a valid/ready output port to the result writer.
- Handles backpressure, partial-window flush and sample indexing.

Parameters:
PW, 8, product input width (unsigned).
KLEN, 3, kernel taps per output sample; legal range 1..16.
AW, 10, accumulator/output width; must satisfy AW >= PW + ceil(log2(KLEN)).
IW, 8, output sample index width.

Ports:
ck  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
prod  input  PW  unsigned product from multiplier stage.
prod_valid  input  1  prod is valid this cycle.
prod_ready  output  1  block accepts prod this cycle.
flush  input  1  synchronous abort of partial window.
acc_out  output  AW  completed convolution sample.
out_valid  output  1  acc_out holds an unconsumed sample.
out_ready  input  1  downstream consumes acc_out this cycle.
out_idx  output  IW  index of sample on acc_out, wraps mod 2^IW.
tap_cnt  output  ceil(log2(KLEN+1))  products accumulated in current window.
busy  output  1  tap_cnt != 0 or out_valid.

Behaviour:
- Reset (rst_n=0, async, immediate): acc=0, tap_cnt=0, acc_out=0, out_valid=0, out_idx=0, busy=0; internal sample counter=0. prod_ready reads 1 once reset releases.
- Accept: prod accepted on a rising edge when prod_valid && prod_ready && !flush.
- prod_ready = !(out_valid && !out_ready); combinational, no dependency on prod_valid.
- Output hold: while out_valid=1 and out_ready=0, all upstream input stalls.
- State IDLE (tap_cnt=0, out_valid=0):
  - Accepted product with KLEN>1: acc <= prod, tap_cnt <= 1, go to ACCUM.
  - Accepted product with KLEN=1: go to emit (see below).
- State ACCUM (0<tap_cnt<KLEN):
  - Non-final accepted product: acc <= acc + prod, tap_cnt++.
  - Final accepted product (tap_cnt = KLEN-1): emit.
- Emit:
  - acc_out <= acc + prod; out_valid <= 1; out_idx <= sample counter.
  - Sample counter increments; acc <= 0; tap_cnt <= 0.
- Latency: final product accepted at edge N gives out_valid=1 and acc_out stable after edge N.
- Output handshake:
  - A sample transfers on an edge with out_valid && out_ready; out_valid then clears unless a new emit occurs on the same edge.
  - New emit on the same edge as a transfer (back-to-back, KLEN=1): out_valid stays 1 and acc_out/out_idx update.
  - acc_out and out_idx hold while out_valid=1 and out_ready=0.
- Window accumulation continues while out_valid=1 and out_ready=1.
- Arithmetic: unsigned, zero-extended to AW, modulo 2^AW. No overflow is possible under the AW constraint. Sum of KLEN=3 products of value 225 is 675.
- flush=1:
  - Next edge: acc <= 0, tap_cnt <= 0.
  - Any product presented that cycle is discarded, even with prod_valid && prod_ready.
  - The output register, out_valid and the sample counter are unaffected.
  - flush while idle is a no-op.
- Sample counter wraps 2^IW-1 -> 0.
- Reset asserted mid-window or with out_valid=1: all state cleared immediately; the pending sample is lost.
- busy = (tap_cnt != 0) || out_valid.

Test Plan:
- Basic, KLEN=3: products 225,225,225 on three consecutive cycles, out_ready=1 -> one cycle after the third accept, acc_out=675, out_valid=1 for exactly 1 cycle, out_idx=0. Next window 1,2,3 -> acc_out=6, out_idx=1.
- Backpressure: complete window 10,20,30 with out_ready=0 -> acc_out=60 held; prod_ready=0 and products 5,5,5 stall. Raise out_ready -> 60 transfers, then 5,5,5 yields 15 with out_idx incremented by 1.
- Flush: accept 100,50, then flush=1 with prod=7 valid -> tap_cnt=0, 7 dropped. Next 1,1,1 -> acc_out=3, out_idx unchanged sequence (no skipped index).
- KLEN=1 streaming, out_ready=1: products 9,8,7 on consecutive cycles -> acc_out 9,8,7 on consecutive cycles, out_valid continuously 1, out_idx 0,1,2.
- Reset mid-operation: after 2 taps of a window plus an unconsumed output, drop rst_n asynchronously between edges -> all outputs 0 immediately. After release, 4,4,4 -> acc_out=12, out_idx=0.
- Index wrap, IW=8: 256 windows of 0,0,1 -> out_idx runs 0..255 then 0, each acc_out=1.
